axi_pkt_rr_arbiter: RTL and testbench
=====================================

// Module: axi_pkt_rr_arbiter
// PURPOSE
//  Packet-granular round-robin arbiter sharing one axi_drop_packet input among NUM_INPUTS AXI-Stream sources.
//  Never interleaves packets. Forwards per-word terror unchanged.
//  Enforces MAX_PKT_SIZE: an oversize packet is cut, its last forwarded word is marked terror so the downstream
//  drop buffer discards it, and the remainder is flushed at the source.
// PARAMETERS
//  WIDTH         32  tdata width per stream
//  NUM_INPUTS    4   number of requesters (>=2)
//  MAX_PKT_SIZE  64  max words per packet; must equal the downstream axi_drop_packet MAX_PKT_SIZE
// PORTS
//  clk       in   1                     clock
//  reset_n   in   1                     asynchronous, active-low reset
//  clear     in   1                     synchronous clear, same effect as reset
//  i_tdata   in   NUM_INPUTS*WIDTH      input data, port p at [p*WIDTH +: WIDTH]
//  i_tvalid  in   NUM_INPUTS            per-port valid
//  i_tlast   in   NUM_INPUTS            per-port last
//  i_terror  in   NUM_INPUTS            per-port error flag
//  i_tready  out  NUM_INPUTS            per-port ready
//  o_tdata   out  WIDTH                 output data (to axi_drop_packet i_tdata)
//  o_tvalid  out  1                     output valid
//  o_tlast   out  1                     output last
//  o_terror  out  1                     output error (to axi_drop_packet i_terror)
//  o_tready  in   1                     output ready
//  o_port    out  $clog2(NUM_INPUTS)    currently or last granted port
//  o_busy    out  1                     1 when state != IDLE
//  o_trunc   out  1                     1-cycle pulse when a packet is truncated
// BEHAVIOUR
//  Reset (reset_n low, async) and clear (sync):
//  - state=IDLE, last_grant=NUM_INPUTS-1, word_cnt=0
//  - o_tvalid=0, i_tready=0, o_trunc=0, o_busy=0, o_port=0
//  IDLE
//  - All i_tready=0; o_tvalid=0.
//  - If any i_tvalid: grant the first requesting port searching last_grant+1 .. wrapping to last_grant.
//  - Register grant into last_grant and o_port, word_cnt=0, go to PASS. Decision uses one cycle (one bubble per packet).
//  PASS (combinational path from granted port g, no added latency)
//  - o_tdata/o_tvalid/o_tlast/o_terror = i_*[g]; i_tready[g]=o_tready; all other i_tready=0.
//  - On each o_tvalid&o_tready: word_cnt++ (range 0..MAX_PKT_SIZE-1; width $clog2(MAX_PKT_SIZE+1)).
//  - Transfer with i_tlast[g]=1: go to IDLE, word_cnt=0.
//  - Word number MAX_PKT_SIZE (word_cnt==MAX_PKT_SIZE-1) with i_tlast[g]=0:
//    - Force o_tlast=1 and o_terror=1 on that word; pulse o_trunc on the transfer cycle.
//    - Go to DISCARD.
//  - A packet of exactly MAX_PKT_SIZE words ending in tlast is normal and not truncated.
//  DISCARD
//  - o_tvalid=0; i_tready[g]=1 regardless of o_tready; words are dropped.
//  - On i_tvalid[g]&i_tlast[g]: go to IDLE.
//  Ordering and stability
//  - Input terror is passed per word; no arbiter-side state depends on it.
//  - Non-granted ports are never acknowledged. A port dropping tvalid mid-packet keeps the grant (no timeout).
//  - With o_tready low, outputs follow the granted input, which is AXI-stable by contract.
//  Simultaneous events
//  - A new request arriving in the cycle a packet ends is seen in the following IDLE cycle.
//  - clear overrides all other state transitions.
//  Reset/clear mid-packet abandons the packet. The downstream drop buffer must be cleared alongside.
//  The arbiter does not regenerate tlast in this case.
// TESTING (WIDTH=32, NUM_INPUTS=4, MAX_PKT_SIZE=64)
//  1. reset_n low 10 cycles, all ports valid
//     -> o_tvalid=0, i_tready=4'b0000, o_busy=0 throughout.
//     After release, first grant is port 0.
//  2. All 4 ports queue 3 packets of 16 words each (data = port<<16 | idx), o_tready=1
//     -> output port order 0,1,2,3 repeated 3x, whole packets, one idle cycle between packets, tlast on each 16th word.
//  3. Only port 2 sends 5 back-to-back packets of 8 words
//     -> all granted to port 2; o_port=2; no data loss.
//  4. Port 1 sends 100 words with tlast on word 100, then port 3 sends 4 words
//     -> 64 words out, word 64 has tlast=1 and terror=1, one o_trunc pulse.
//     The remaining 36 words are consumed with o_tvalid=0; the port 3 packet follows intact.
//  5. Port 0 sends 64 words, tlast on word 64, terror=1 only on word 10
//     -> 64 words out, o_terror=1 only on word 10, o_trunc stays 0.
//  6. Random o_tready and random source gaps over 2000 packets, plus one clear pulse mid-packet
//     -> per-port data in order, no interleaving.
//     After clear: o_tvalid=0 next cycle, and the next grant starts at port 0.

Source files
------------

// File: rtl/axi_pkt_rr_arbiter.sv
// rtl/axi_pkt_rr_arbiter.sv - packet-granular round-robin arbiter with max-size truncation
//
// Shares one downstream AXI-Stream consumer among NUM_INPUTS sources, one whole
// packet at a time. A packet longer than MAX_PKT_SIZE words is cut: its last
// forwarded word carries tlast+terror so the drop buffer discards it, and the
// rest of the packet is drained from the source without being forwarded.
//
// Ports:
//   clk, reset_n (async, active-low), clear (sync, same effect as reset)
//   i_tdata/i_tvalid/i_tlast/i_terror/i_tready : per-source streams, port p at [p*WIDTH +: WIDTH]
//   o_tdata/o_tvalid/o_tlast/o_terror/o_tready : arbitrated output stream
//   o_port  : currently or last granted port
//   o_busy  : high while a packet is granted (PASS or DISCARD)
//   o_trunc : one-cycle pulse on the transfer that truncates a packet
module axi_pkt_rr_arbiter #(
    parameter int WIDTH        = 32,
    parameter int NUM_INPUTS   = 4,
    parameter int MAX_PKT_SIZE = 64
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              clear,
    input  logic [NUM_INPUTS*WIDTH-1:0]       i_tdata,
    input  logic [NUM_INPUTS-1:0]             i_tvalid,
    input  logic [NUM_INPUTS-1:0]             i_tlast,
    input  logic [NUM_INPUTS-1:0]             i_terror,
    output logic [NUM_INPUTS-1:0]             i_tready,
    output logic [WIDTH-1:0]                  o_tdata,
    output logic                              o_tvalid,
    output logic                              o_tlast,
    output logic                              o_terror,
    input  logic                              o_tready,
    output logic [$clog2(NUM_INPUTS)-1:0]     o_port,
    output logic                              o_busy,
    output logic                              o_trunc
);
    localparam int PW = $clog2(NUM_INPUTS);
    localparam int CW = $clog2(MAX_PKT_SIZE + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PASS    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [PW-1:0]    last_grant_q, last_grant_d;
    logic [PW-1:0]    port_q, port_d;
    logic [CW-1:0]    word_cnt_q, word_cnt_d;

    logic [WIDTH-1:0] sel_tdata;
    logic             sel_tvalid;
    logic             sel_tlast;
    logic             sel_terror;

    logic             req_found;
    logic [PW-1:0]    req_port;
    int               cand_i;
    logic [PW-1:0]    cand;

    logic             at_limit;
    logic             xfer;

    // Mux of the granted source; port_q is held through PASS and DISCARD.
    always_comb begin
        sel_tdata  = '0;
        sel_tvalid = 1'b0;
        sel_tlast  = 1'b0;
        sel_terror = 1'b0;
        for (int p = 0; p < NUM_INPUTS; p++) begin
            if (port_q == PW'(p)) begin
                sel_tdata  = i_tdata[p*WIDTH +: WIDTH];
                sel_tvalid = i_tvalid[p];
                sel_tlast  = i_tlast[p];
                sel_terror = i_terror[p];
            end
        end
    end

    // Round-robin search starting just after the last grant and wrapping
    // around to the last grant itself, so a lone requester can win repeatedly.
    always_comb begin
        req_found = 1'b0;
        req_port  = last_grant_q;
        cand_i    = 0;
        cand      = '0;
        for (int i = 1; i <= NUM_INPUTS; i++) begin
            cand_i = (int'(last_grant_q) + i) % NUM_INPUTS;
            cand   = PW'(cand_i);
            if (!req_found && i_tvalid[cand]) begin
                req_found = 1'b1;
                req_port  = cand;
            end
        end
    end

    // at_limit marks the MAX_PKT_SIZE-th word of the current packet.
    assign at_limit = (word_cnt_q == CW'(MAX_PKT_SIZE - 1));
    assign xfer     = (state_q == ST_PASS) && sel_tvalid && o_tready;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        port_d       = port_q;
        word_cnt_d   = word_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_found) begin
                    state_d      = ST_PASS;
                    last_grant_d = req_port;
                    port_d       = req_port;
                    word_cnt_d   = '0;
                end
            end
            ST_PASS: begin
                if (xfer) begin
                    if (sel_tlast) begin
                        state_d    = ST_IDLE;
                        word_cnt_d = '0;
                    end else if (at_limit) begin
                        state_d    = ST_DISCARD;
                        word_cnt_d = '0;
                    end else begin
                        word_cnt_d = word_cnt_q + CW'(1);
                    end
                end
            end
            ST_DISCARD: begin
                if (sel_tvalid && sel_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (clear) begin
            state_d      = ST_IDLE;
            last_grant_d = PW'(NUM_INPUTS - 1);
            port_d       = '0;
            word_cnt_d   = '0;
        end
    end

    // Output path is purely combinational from the granted source in PASS.
    // On the limit word without a real tlast, tlast and terror are forced so
    // the downstream drop buffer closes and discards the partial packet.
    always_comb begin
        o_tdata  = sel_tdata;
        o_tvalid = 1'b0;
        o_tlast  = 1'b0;
        o_terror = 1'b0;
        o_trunc  = 1'b0;
        i_tready = '0;
        if (state_q == ST_PASS) begin
            o_tvalid         = sel_tvalid;
            o_tlast          = sel_tlast | at_limit;
            o_terror         = sel_terror | (at_limit & ~sel_tlast);
            o_trunc          = xfer & at_limit & ~sel_tlast;
            i_tready[port_q] = o_tready;
        end else if (state_q == ST_DISCARD) begin
            i_tready[port_q] = 1'b1;
        end
    end

    assign o_port = port_q;
    assign o_busy = (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= PW'(NUM_INPUTS - 1);
            port_q       <= '0;
            word_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            word_cnt_q   <= word_cnt_d;
        end
    end

endmodule

// File: tb/tb_axi_pkt_rr_arbiter.sv
// tb/tb_axi_pkt_rr_arbiter.sv - self-checking bench for axi_pkt_rr_arbiter
module tb_axi_pkt_rr_arbiter;
    localparam int NP    = 4;
    localparam int W     = 32;
    localparam int MAXP  = 64;
    localparam int DEPTH = 8192;
    localparam int OUTD  = 16384;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            clear;
    logic [NP*W-1:0] i_tdata;
    logic [NP-1:0]   i_tvalid;
    logic [NP-1:0]   i_tlast;
    logic [NP-1:0]   i_terror;
    logic [NP-1:0]   i_tready;
    logic [W-1:0]    o_tdata;
    logic            o_tvalid;
    logic            o_tlast;
    logic            o_terror;
    logic            o_tready;
    logic [1:0]      o_port;
    logic            o_busy;
    logic            o_trunc;

    axi_pkt_rr_arbiter #(.WIDTH(W), .NUM_INPUTS(NP), .MAX_PKT_SIZE(MAXP)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tlast(i_tlast),
        .i_terror(i_terror), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tvalid(o_tvalid), .o_tlast(o_tlast),
        .o_terror(o_terror), .o_tready(o_tready),
        .o_port(o_port), .o_busy(o_busy), .o_trunc(o_trunc)
    );

    always #5 clk = ~clk;

    // Source word store: {data, last, err}; data = {port, index-in-stream}.
    logic [33:0] src_mem [NP][DEPTH];
    int          wr_p [NP];
    int          rd_p [NP];
    logic        vld  [NP];
    int          rdy_pct, gap_pct;

    logic [31:0] out_data [OUTD];
    logic        out_last [OUTD];
    logic        out_err  [OUTD];
    logic [1:0]  out_port [OUTD];
    int          out_cyc  [OUTD];
    int          n_out, trunc_cnt, cyc;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        int port;
        int nwords;
        int err_at;
        int rdy;
        int exp_out;
        int exp_trunc;
    } vec_t;
    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_pkt(input int p, input int len, input int err_at);
        for (int k = 1; k <= len; k++) begin
            src_mem[p][wr_p[p]] = {16'(p), 16'(wr_p[p]), (k == len), (k == err_at)};
            wr_p[p]++;
        end
    endtask

    task automatic clear_bench();
        for (int p = 0; p < NP; p++) begin
            wr_p[p] = 0;
            rd_p[p] = 0;
            vld[p]  = 1'b0;
        end
        n_out     = 0;
        trunc_cnt = 0;
    endtask

    function automatic bit all_empty();
        bit e;
        e = 1'b1;
        for (int p = 0; p < NP; p++) if (rd_p[p] != wr_p[p]) e = 1'b0;
        return e;
    endfunction

    // Sample at negedge (values that the next posedge commits), drive #1 after posedge.
    task automatic cycle();
        logic [33:0] word;
        @(negedge clk);
        if (o_trunc) trunc_cnt++;
        if (o_tvalid && o_tready && n_out < OUTD) begin
            out_data[n_out] = o_tdata;
            out_last[n_out] = o_tlast;
            out_err[n_out]  = o_terror;
            out_port[n_out] = o_port;
            out_cyc[n_out]  = cyc;
            n_out++;
        end
        for (int p = 0; p < NP; p++) begin
            if (i_tvalid[p] && i_tready[p]) begin
                rd_p[p]++;
                vld[p] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int p = 0; p < NP; p++) begin
            if (!vld[p])
                vld[p] = (rd_p[p] != wr_p[p]) && ((gap_pct == 0) || ($urandom_range(0, 99) >= gap_pct));
            i_tvalid[p] = vld[p];
            if (vld[p]) begin
                word = src_mem[p][rd_p[p]];
                i_tdata[p*W +: W] = word[33:2];
                i_tlast[p]        = word[1];
                i_terror[p]       = word[0];
            end else begin
                i_tdata[p*W +: W] = '0;
                i_tlast[p]        = 1'b0;
                i_terror[p]       = 1'b0;
            end
        end
        o_tready = (rdy_pct >= 100) || ($urandom_range(0, 99) < rdy_pct);
    endtask

    task automatic drain(input string name, input int bound);
        bit done;
        done = 1'b0;
        for (int k = 0; k < bound && !done; k++) begin
            cycle();
            done = all_empty() && !o_busy;
        end
        n_cmp++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", name, bound);
        end
    endtask

    // Every output word must be the next word of its source, on the reported
    // port, with no other port appearing inside an open packet.
    task automatic check_stream(input string name);
        int exp_seq [NP];
        int bad, p, cur;
        bit in_pkt;
        logic [33:0] e;
        bad = 0; cur = 0; in_pkt = 1'b0;
        for (int q = 0; q < NP; q++) exp_seq[q] = 0;
        for (int i = 0; i < n_out; i++) begin
            p = int'(out_data[i][31:16]);
            if (p >= NP || exp_seq[p] >= wr_p[p]) begin
                bad++;
            end else begin
                e = src_mem[p][exp_seq[p]];
                if (out_data[i] !== e[33:2] || out_last[i] !== e[1] || out_err[i] !== e[0] ||
                    int'(out_port[i]) != p || (in_pkt && p != cur))
                    bad++;
                exp_seq[p]++;
                in_pkt = !out_last[i];
                cur    = p;
            end
        end
        for (int q = 0; q < NP; q++) if (exp_seq[q] != wr_p[q]) bad++;
        check(name, bad, 0);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int bad, k, ea;
        vecs[0] = '{1, 100,  0, 100, 64, 1};
        vecs[1] = '{0,  64, 10, 100, 64, 0};
        vecs[2] = '{2,  65,  0,  60, 64, 1};
        vecs[3] = '{3,   1,  1, 100,  1, 0};
        vecs[4] = '{0,  63,  0,  50, 63, 0};
        vecs[5] = '{3,  64, 64,  75, 64, 0};
        vecs[6] = '{1,  70, 64, 100, 64, 1};

        reset_n = 1'b0; clear = 1'b0; o_tready = 1'b0;
        i_tdata = '0; i_tvalid = '0; i_tlast = '0; i_terror = '0;
        rdy_pct = 100; gap_pct = 0; cyc = 0;
        clear_bench();

        // Reset held with every port requesting.
        for (int p = 0; p < NP; p++) for (int j = 0; j < 3; j++) push_pkt(p, 16, 0);
        bad = 0;
        for (int j = 0; j < 10; j++) begin
            cycle();
            if (o_tvalid !== 1'b0 || i_tready !== 4'b0000 || o_busy !== 1'b0 || o_trunc !== 1'b0) bad++;
        end
        check("reset_quiet_cycles", bad, 0);
        check("reset_o_port", o_port, 0);
        check("reset_i_tready", i_tready, 0);
        reset_n = 1'b1;

        // Four ports, three 16-word packets each.
        drain("t2", 1000);
        check("t2_nout", n_out, 192);
        check("t2_first_grant", out_port[0], 0);
        bad = 0;
        for (int pk = 0; pk < 12; pk++) if (int'(out_port[pk*16]) != pk % 4) bad++;
        check("t2_port_order", bad, 0);
        bad = 0;
        for (int i = 1; i < 192; i++) begin
            if ((i % 16) == 0) begin
                if (out_cyc[i] - out_cyc[i-1] != 2) bad++;
            end else if (out_cyc[i] - out_cyc[i-1] != 1) bad++;
        end
        check("t2_bubble_spacing", bad, 0);
        check_stream("t2_stream");
        check("t2_trunc", trunc_cnt, 0);

        // Single requester, back-to-back packets.
        clear_bench();
        for (int j = 0; j < 5; j++) push_pkt(2, 8, 0);
        drain("t3", 500);
        check("t3_nout", n_out, 40);
        bad = 0;
        for (int i = 0; i < 40; i++) if (out_port[i] !== 2'd2) bad++;
        check("t3_all_port2", bad, 0);
        check("t3_o_port", o_port, 2);
        check_stream("t3_stream");

        // Oversize packet on port 1 followed by a short packet on port 3.
        clear_bench();
        push_pkt(1, 100, 0);
        k = 0;
        while (!(o_busy && o_port == 2'd1) && k < 10) begin cycle(); k++; end
        push_pkt(3, 4, 0);
        drain("t4", 1000);
        check("t4_nout", n_out, 68);
        check("t4_trunc", trunc_cnt, 1);
        check("t4_word64", {out_data[63], out_last[63], out_err[63]}, {16'd1, 16'd63, 1'b1, 1'b1});
        bad = 0;
        for (int i = 0; i < 63; i++)
            if (out_data[i] !== {16'd1, 16'(i)} || out_last[i] || out_err[i]) bad++;
        for (int i = 0; i < 4; i++)
            if (out_data[64+i] !== {16'd3, 16'(i)} || out_last[64+i] !== (i == 3) || out_err[64+i]) bad++;
        check("t4_words", bad, 0);
        check("t4_src1_drained", rd_p[1], 100);

        // Single-packet vectors: length, error position, ready pattern.
        for (int v = 0; v < 7; v++) begin
            clear_bench();
            rdy_pct = vecs[v].rdy;
            push_pkt(vecs[v].port, vecs[v].nwords, vecs[v].err_at);
            drain($sformatf("vec%0d", v), 2000);
            check($sformatf("vec%0d_nout", v), n_out, vecs[v].exp_out);
            check($sformatf("vec%0d_trunc", v), trunc_cnt, vecs[v].exp_trunc);
            bad = 0;
            for (int i = 0; i < vecs[v].exp_out; i++) begin
                ea = ((i + 1) == vecs[v].err_at) || (vecs[v].exp_trunc != 0 && i == vecs[v].exp_out - 1);
                if (out_data[i] !== {16'(vecs[v].port), 16'(i)} ||
                    out_last[i] !== (i == vecs[v].exp_out - 1) ||
                    out_err[i]  !== ea[0] ||
                    int'(out_port[i]) != vecs[v].port)
                    bad++;
            end
            check($sformatf("vec%0d_words", v), bad, 0);
        end

        // Random traffic: random ready, random source gaps.
        clear_bench();
        rdy_pct = 70; gap_pct = 30;
        for (int j = 0; j < 2000; j++) begin
            k = $urandom_range(1, 10);
            push_pkt($urandom_range(0, 3), k, $urandom_range(0, k));
        end
        drain("t6", 60000);
        check_stream("t6_stream");
        check("t6_trunc", trunc_cnt, 0);

        // Clear in the middle of a packet.
        clear_bench();
        rdy_pct = 100; gap_pct = 0;
        push_pkt(2, 20, 0);
        k = 0;
        while (n_out < 5 && k < 50) begin cycle(); k++; end
        check("clr_pre_port", o_port, 2);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        clear_bench();
        i_tvalid = '0; i_tlast = '0; i_terror = '0;
        check("clr_o_tvalid", o_tvalid, 0);
        check("clr_o_busy", o_busy, 0);
        check("clr_o_port", o_port, 0);
        check("clr_i_tready", i_tready, 0);
        push_pkt(3, 4, 0);
        push_pkt(0, 4, 0);
        drain("clr_post", 100);
        check("clr_nout", n_out, 8);
        check("clr_first_grant", out_port[0], 0);
        check_stream("clr_stream");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
